// File: rtl/rnd_postproc_if.sv
// Output byte stream of the random post-processor.
// Valid/ready handshake between producer and consumer.
interface rnd_postproc_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/rnd_postproc.sv
// Raw TRNG post-processing: repetition-count health test,
// von Neumann debias, byte assembly and output byte FIFO.
module rnd_postproc #(
   parameter int FIFO_DEPTH = 4,
   parameter int RCT_LIMIT  = 32
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       raw_valid,
   input  logic       raw_bit,
   input  logic       clr_fail,
   output logic       health_fail,
   output logic [7:0] drop_cnt,
   rnd_postproc_if.master out_if
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [7:0] LIM = 8'(RCT_LIMIT);

   typedef enum logic {
      EMPTY,
      HAVE_FIRST
   } deb_state_e;

   logic [7:0] run_q, run_d;
   logic       prev_q;
   logic       trip, halt;

   always_comb begin
      run_d = run_q;
      if (run_q == 8'd0 || raw_bit != prev_q)
         run_d = 8'd1;
      else if (run_q != LIM)
         run_d = run_q + 8'd1;
   end

   // the tripping sample itself is already excluded from debiasing
   assign trip = raw_valid & ~clr_fail & (run_d == LIM);
   assign halt = health_fail | trip;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         run_q       <= 8'd0;
         prev_q      <= 1'b0;
         health_fail <= 1'b0;
      end else if (clr_fail) begin
         run_q       <= 8'd0;
         prev_q      <= 1'b0;
         health_fail <= 1'b0;
      end else if (raw_valid) begin
         run_q  <= run_d;
         prev_q <= raw_bit;
         if (trip)
            health_fail <= 1'b1;
      end
   end

   deb_state_e state_q, state_d;
   logic       first_q, first_d;
   logic       deb_valid;

   always_comb begin
      state_d   = state_q;
      first_d   = first_q;
      deb_valid = 1'b0;
      if (clr_fail || halt) begin
         state_d = EMPTY;
      end else if (raw_valid) begin
         unique case (state_q)
            EMPTY: begin
               state_d = HAVE_FIRST;
               first_d = raw_bit;
            end
            HAVE_FIRST: begin
               state_d   = EMPTY;
               deb_valid = (first_q != raw_bit);
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= EMPTY;
         first_q <= 1'b0;
      end else begin
         state_q <= state_d;
         first_q <= first_d;
      end
   end

   // pair 1,0 -> 1 and 0,1 -> 0, so the debiased bit is the first bit
   logic [6:0] asm_q;
   logic [2:0] bcnt_q;
   logic       push_req;
   logic [7:0] push_byte;

   assign push_req  = deb_valid & (bcnt_q == 3'd7);
   assign push_byte = {asm_q, first_q};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         asm_q  <= 7'd0;
         bcnt_q <= 3'd0;
      end else if (clr_fail || halt) begin
         asm_q  <= 7'd0;
         bcnt_q <= 3'd0;
      end else if (deb_valid) begin
         asm_q  <= {asm_q[5:0], first_q};
         bcnt_q <= bcnt_q + 3'd1;
      end
   end

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_q;
   logic          full, pop, push, drop;

   assign full = (count_q == CW'(FIFO_DEPTH));
   assign pop  = out_if.out_valid & out_if.out_ready;
   assign push = push_req & (~full | pop);
   assign drop = push_req & full & ~pop;

   assign out_if.out_valid = (count_q != '0);
   assign out_if.out_data  = out_if.out_valid ? mem[rd_ptr] : 8'h00;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_byte;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count_q  <= '0;
         drop_cnt <= 8'd0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (drop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_rnd_postproc.sv
// Randomized bench for rnd_postproc against a queue-based
// model of debias, byte assembly, health test and FIFO.
module tb_rnd_postproc;

   localparam int DEPTH = 4;
   localparam int RCT   = 32;

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       raw_valid = 1'b0;
   logic       raw_bit = 1'b0;
   logic       clr_fail = 1'b0;
   logic       health_fail;
   logic [7:0] drop_cnt;

   rnd_postproc_if oif ();

   rnd_postproc #(
      .FIFO_DEPTH(DEPTH),
      .RCT_LIMIT (RCT)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .raw_valid  (raw_valid),
      .raw_bit    (raw_bit),
      .clr_fail   (clr_fail),
      .health_fail(health_fail),
      .drop_cnt   (drop_cnt),
      .out_if     (oif)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   // model state: pending first bit (-1 none), collected bits, bytes
   int fifo_q[$];
   int bits_q[$];
   int m_first, m_run, m_prev, m_drop;
   bit m_fail;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      fifo_q.delete();
      bits_q.delete();
      m_first = -1;
      m_run   = 0;
      m_prev  = 0;
      m_drop  = 0;
      m_fail  = 1'b0;
   endtask

   task automatic model_update();
      bit pop;
      bit have;
      int byte_v;
      pop    = (fifo_q.size() != 0) && oif.out_ready;
      have   = 1'b0;
      byte_v = 0;
      if (clr_fail) begin
         m_fail  = 1'b0;
         m_run   = 0;
         m_first = -1;
         bits_q.delete();
      end else if (raw_valid) begin
         if (m_run == 0 || int'(raw_bit) != m_prev)
            m_run = 1;
         else if (m_run < RCT)
            m_run++;
         m_prev = int'(raw_bit);
         if (m_run == RCT)
            m_fail = 1'b1;
         if (m_fail) begin
            m_first = -1;
            bits_q.delete();
         end else if (m_first < 0) begin
            m_first = int'(raw_bit);
         end else begin
            if (m_first != int'(raw_bit))
               bits_q.push_back(m_first);
            m_first = -1;
            if (bits_q.size() == 8) begin
               foreach (bits_q[i])
                  byte_v = byte_v * 2 + bits_q[i];
               bits_q.delete();
               have = 1'b1;
            end
         end
      end
      if (pop)
         void'(fifo_q.pop_front());
      if (have) begin
         if (fifo_q.size() < DEPTH)
            fifo_q.push_back(byte_v);
         else if (m_drop < 255)
            m_drop++;
      end
   endtask

   always @(negedge clk) begin : cmp
      int exp_v;
      int exp_d;
      if (chk_en) begin
         exp_v = (fifo_q.size() != 0) ? 1 : 0;
         exp_d = exp_v ? fifo_q[0] : 0;
         chk("out_valid", int'(oif.out_valid), exp_v);
         chk("out_data", int'(oif.out_data), exp_d);
         chk("health_fail", int'(health_fail), int'(m_fail));
         chk("drop_cnt", int'(drop_cnt), m_drop);
      end
   end

   // called at a negedge; returns at the following negedge
   task automatic step(input logic rv, input logic rb,
                       input logic clr, input logic rdy);
      raw_valid     = rv;
      raw_bit       = rb;
      clr_fail      = clr;
      oif.out_ready = rdy;
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic rdy,
                            input logic rdy_last, input bit junk);
      for (int i = 7; i >= 0; i--) begin
         if (junk)
            step(1'b1, logic'(i[0]), 1'b0, rdy);
         if (junk)
            step(1'b1, logic'(i[0]), 1'b0, rdy);
         step(1'b1, b[i], 1'b0, rdy);
         step(1'b1, ~b[i], 1'b0, (i == 0) ? rdy_last : rdy);
      end
   endtask

   task automatic do_reset();
      #2;
      rstn      = 1'b0;
      raw_valid = 1'b0;
      clr_fail  = 1'b0;
      model_reset();
      @(negedge clk);
      chk("rst_out_valid", int'(oif.out_valid), 0);
      chk("rst_out_data", int'(oif.out_data), 0);
      chk("rst_health", int'(health_fail), 0);
      chk("rst_drop", int'(drop_cnt), 0);
      #2;
      rstn = 1'b1;
      step(1'b0, 1'b0, 1'b0, oif.out_ready);
   endtask

   logic [7:0] bq [6];
   int         pct;

   initial begin
      oif.out_ready = 1'b0;
      #1;
      rstn = 1'b0;
      model_reset();
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      chk("init_out_valid", int'(oif.out_valid), 0);
      chk("init_out_data", int'(oif.out_data), 0);
      chk("init_health", int'(health_fail), 0);
      chk("init_drop", int'(drop_cnt), 0);
      #2;
      rstn = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // single byte from alternating pairs
      send_byte(8'hB2, 1'b1, 1'b1, 1'b0);
      chk("b2_valid", int'(oif.out_valid), 1);
      chk("b2_data", int'(oif.out_data), 'hB2);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("b2_popped", int'(oif.out_valid), 0);

      // equal pairs interleaved must contribute nothing
      send_byte(8'hB2, 1'b1, 1'b1, 1'b1);
      chk("junk_data", int'(oif.out_data), 'hB2);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("junk_no_extra", int'(oif.out_valid), 0);

      // overflow: six bytes into four entries
      for (int k = 0; k < 6; k++) begin
         bq[k] = 8'($urandom);
         send_byte(bq[k], 1'b0, 1'b0, 1'b0);
      end
      chk("ovf_drop", int'(drop_cnt), 2);
      chk("ovf_head", int'(oif.out_data), int'(bq[0]));

      // push and pop together while full
      send_byte(8'h5C, 1'b0, 1'b1, 1'b0);
      chk("full_pp_drop", int'(drop_cnt), 2);
      chk("full_pp_head", int'(oif.out_data), int'(bq[1]));
      for (int k = 0; k < 4; k++)
         step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("full_pp_drained", int'(oif.out_valid), 0);

      // repetition-count failure and recovery
      step(1'b0, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < RCT; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b1);
         if (k == RCT - 2)
            chk("rct_not_yet", int'(health_fail), 0);
      end
      chk("rct_trip", int'(health_fail), 1);
      send_byte(8'h3A, 1'b1, 1'b1, 1'b0);
      chk("rct_no_bytes", int'(oif.out_valid), 0);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      chk("rct_cleared", int'(health_fail), 0);
      send_byte(8'hB2, 1'b0, 1'b0, 1'b0);
      chk("rct_recover", int'(oif.out_data), 'hB2);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // reset after five debiased bits drops the partial byte
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         step(1'b1, 1'b0, 1'b0, 1'b0);
      end
      do_reset();
      send_byte(8'hB2, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_data", int'(oif.out_data), 'hB2);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("rst_mid_one", int'(oif.out_valid), 0);

      // random traffic with varying bit bias
      for (int seg = 0; seg < 6; seg++) begin
         pct = (seg % 3 == 0) ? 50 : ((seg % 3 == 1) ? 85 : 97);
         for (int c = 0; c < 500; c++) begin
            step($urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) < pct,
                 $urandom_range(0, 149) == 0,
                 $urandom_range(0, 2) != 0);
         end
         if (seg == 2)
            do_reset();
      end

      // saturate the drop counter
      step(1'b0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 262; k++)
         send_byte(8'($urandom), 1'b0, 1'b0, 1'b0);
      chk("drop_sat", int'(drop_cnt), 255);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rnd_postproc.md
RND_POSTPROC -- requirements
Module: rnd_postproc

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output byte FIFO entries (power of two, 2..16).
REQ-002 Parameter RCT_LIMIT, default 32, consecutive identical raw bits that trip the health test (2..255).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 raw_valid  input  1  one-cycle strobe; raw_bit is a new sample from the random source.
REQ-006 raw_bit  input  1  raw random bit, qualified by raw_valid.
REQ-007 clr_fail  input  1  synchronous pulse; clears health failure and restarts processing.
REQ-008 out_data  output  8  FIFO head byte, valid while out_valid=1.
REQ-009 out_valid  output  1  FIFO not empty.
REQ-010 out_ready  input  1  consumer accepts out_data when out_valid&out_ready.
REQ-011 health_fail  output  1  sticky repetition-count failure flag.
REQ-012 drop_cnt  output  8  saturating count of bytes lost to FIFO full.

Function
REQ-013 Debias state machine SHALL have states EMPTY and HAVE_FIRST; raw_valid in EMPTY stores raw_bit as first and moves to HAVE_FIRST.
REQ-014 raw_valid in HAVE_FIRST returns to EMPTY; pair 0,1 yields debiased bit 0, pair 1,0 yields bit 1, pairs 0,0 and 1,1 yield nothing.
REQ-015 Assembler SHALL shift each debiased bit into a byte register MSB-first (first bit ends in out_data[7]) and count bits 0..7.
REQ-016 On the 8th bit the assembled byte SHALL be pushed in the same clock edge and the bit counter wraps to 0; no bits are lost across byte boundaries.
REQ-017 Push completes on the edge of the completing raw_valid; out_valid SHALL be 1 the next cycle when FIFO was empty (1-cycle latency).
REQ-018 Pop occurs on every cycle with out_valid&out_ready; out_data SHALL present the next entry the following cycle.
REQ-019 Push when full with no pop in the same cycle SHALL discard the new byte and increment drop_cnt, saturating at 255.
REQ-020 Push and pop in the same cycle when full SHALL both succeed; occupancy unchanged, no drop.
REQ-021 Push and pop in the same cycle when occupancy is 1 SHALL keep out_valid=1, presenting the pushed byte next.
REQ-022 Repetition-count test SHALL operate on raw bits (before debiasing): run counter resets to 1 on a bit differing from the previous raw bit, increments on an equal bit, saturates at RCT_LIMIT.
REQ-023 When run counter reaches RCT_LIMIT, health_fail SHALL assert the same edge and stay set until clr_fail or reset.
REQ-024 While health_fail=1: no pushes, debias state held at EMPTY, partial byte and bit counter held at 0; FIFO contents already stored remain poppable.
REQ-025 clr_fail SHALL clear health_fail, run counter (0, no previous bit), debias state, partial byte and bit counter; FIFO and drop_cnt unaffected.
REQ-026 clr_fail coincident with raw_valid SHALL take priority; that sample is ignored.
REQ-027 drop_cnt SHALL only be cleared by reset.

Reset
REQ-028 rstn=0 SHALL immediately force: out_valid=0, out_data=8'h00, health_fail=0, drop_cnt=0, FIFO empty, debias EMPTY, bit counter 0, run counter 0.
REQ-029 Reset asserted mid-byte or mid-pair SHALL discard partial data; first raw_valid after release starts a new pair.

Verification
REQ-030 Raw pairs 10,01,10,10,01,01,10,01 with out_ready=1 -> single byte 8'hB2 (bits 1,0,1,1,0,0,1,0), out_valid one cycle after 16th strobe.
REQ-031 Pairs 00 and 11 interleaved into REQ-030 stream -> same 8'hB2, no extra bytes.
REQ-032 out_ready=0, FIFO_DEPTH=4, 6 bytes generated -> out_valid=1, drop_cnt=2, then draining returns first 4 bytes in order.
REQ-033 RCT_LIMIT=32, 32 consecutive raw 1s -> health_fail=1 on 32nd strobe, no further bytes; clr_fail then REQ-030 stream -> health_fail=0, byte 8'hB2.
REQ-034 Full FIFO with simultaneous push and pop -> occupancy stays 4, drop_cnt unchanged, order preserved.
REQ-035 rstn pulsed after 5 debiased bits, then REQ-030 stream -> exactly one byte 8'hB2, all outputs at reset values during reset.
